ln_sequencer: RTL and testbench
===============================

LN_SEQUENCER -- requirements
Module: ln_sequencer

Interface
REQ-001 Parameter: DEGREE, 7, number of polynomial coefficients c1..cDEGREE used in the Horner evaluation.
REQ-002 Ports, one per line, as name, direction, width, meaning:
  clk  in  1  single clock; all state changes on its rising edge.
  rst  in  1  reset; synchronous, active-high.
  in_valid  in  1  the operand in in_a is valid.
  in_ready  out  1  the block can accept an operand.
  in_a  in  32  IEEE-754 single-precision operand A.
  out_valid  out  1  out_y holds ln(A).
  out_ready  in  1  the consumer accepts out_y.
  out_y  out  32  IEEE-754 single-precision ln(A).
  busy  out  1  high in every state except IDLE.
  mul_a, mul_b  out  32  operands sent to the shared combinational FP multiplier.
  mul_y  in  32  product returned by the shared FP multiplier.
  add_a, add_b  out  32  operands sent to the shared combinational FP adder.
  add_y  in  32  sum returned by the shared FP adder.

Function
REQ-003 Computation: ln(A) = n*LN2 + u*P(u), where u = x - 1 and P(u) = c1 + c2*u + ... + cDEGREE*u^(DEGREE-1).
REQ-004 n and x (n as a float, x in [1,2)) come from the range-reduction sub-module, which is combinational on the latched operand.
REQ-005 Handshake: in_ready = (state==IDLE) && !rst; an operand is accepted when in_valid && in_ready, and in_a is latched on that edge.
REQ-006 FSM states: IDLE, REDUCE, HMUL, HADD, FMUL, SMUL, SADD, DONE.
REQ-007 IDLE -> REDUCE on accept of a normal positive finite A.
REQ-008 IDLE -> DONE on accept of a special-case operand (REQ-014).
REQ-009 REDUCE: add_a = x, add_b = 0xBF800000 (-1.0); u <= add_y; acc <= cDEGREE; k <= DEGREE-1; next state HMUL.
REQ-010 HMUL: mul_a = acc, mul_b = u; acc <= mul_y; next state HADD.
REQ-011 HADD: add_a = acc, add_b = c[k]; acc <= add_y; k decrements.
  - If k==1 in HADD, next state is FMUL; otherwise next state is HMUL.
REQ-012 Final sequence, one state per cycle:
  - FMUL: acc <= acc*u, next SMUL.
  - SMUL: t <= n*LN2, next SADD.
  - SADD: out_y <= acc + t, next DONE.
REQ-013 Latency: out_valid first goes high 2*DEGREE+2 cycles after the accept edge (16 for DEGREE=7).
REQ-014 Special cases are resolved on the accept edge, and out_valid goes high 1 cycle after accept:
  - A = +/-0 or denormal: out_y = 0xFF800000 (-inf).
  - A negative non-zero, or NaN: out_y = 0x7FC00000.
  - A = +inf: out_y = 0x7F800000.
REQ-015 DONE: out_valid = 1 and out_y is held stable until out_ready; DONE -> IDLE on the out_ready edge.
REQ-016 in_ready is 0 during DONE, so no new operand is accepted until the result is taken.
REQ-017 When the shared multiplier or adder is not used in the current state, its operands are driven to 0x00000000.
REQ-018 Only one shared unit is driven per cycle (either multiplier or adder), so an external arbiter can grant the other one.
REQ-019 Accuracy: for normal A > 0, |out_y - ln(A)| < 1e-3.
REQ-020 A = 1.0 gives u = 0, so out_y = +0.0 or -0.0.

Reset
REQ-021 While rst is high at an edge: state <= IDLE, out_valid <= 0, out_y <= 0, acc/u/t/k <= 0, busy = 0, in_ready = 0.
REQ-022 Reset asserted mid-operation (any state, including DONE with out_valid high) aborts the operation with no output, and the result is lost.
REQ-023 in_ready goes high in the first cycle after rst deasserts.

Structure
REQ-024 Shared package ln_pkg contains:
  - state enum;
  - LN2 = 0x3F317218, NEG_ONE = 0xBF800000;
  - NEG_INF, POS_INF, QNAN constants;
  - minimax coefficient table LN_COEF[1..DEGREE], fitted on u in [0,1) with max error <= 1e-4.
REQ-025 One sub-module is instantiated: the existing adjustForLn range-reduction block, fed from the latched operand.
REQ-026 The FP multiplier and FP adder sit outside this block; a bench wraps ln_sequencer with one multiply instance and one add instance.

Verification
REQ-027 A = 2.0 (0x40000000) -> out_y within 1e-3 of 0.693147; out_valid 16 cycles after accept.
REQ-028 A = 1.0 -> out_y = +/-0.0.
REQ-029 A = 100.0 -> out_y within 1e-3 of 4.605170; A = 0.5 -> out_y within 1e-3 of -0.693147.
REQ-030 Special cases -> out_valid 1 cycle after accept:
  - A = 0.0 -> out_y = 0xFF800000;
  - A = -1.0 -> out_y = 0x7FC00000;
  - A = +inf -> out_y = 0x7F800000.
REQ-031 Backpressure: out_ready held low for 5 cycles in DONE -> out_y stable, in_ready 0, and IDLE entered on the edge where out_ready = 1.
REQ-032 Reset mid-operation: rst pulsed in HMUL -> out_valid never rises, in_ready = 1 the cycle after release, and the next operand A = 2.0 completes correctly.

Source files
------------

// File: rtl/ln_pkg.sv
// Shared definitions for the natural-log sequencer: FSM states, IEEE-754
// constants, the polynomial coefficient table and operand classification.
package ln_pkg;

  localparam int LN_DEGREE = 7;

  // IEEE-754 single-precision exponent bias.
  localparam logic [7:0] FP_BIAS = 8'd127;

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    HMUL,
    HADD,
    FMUL,
    SMUL,
    SADD,
    DONE
  } state_e;

  localparam logic [31:0] LN2     = 32'h3F317218;
  localparam logic [31:0] NEG_ONE = 32'hBF800000;
  localparam logic [31:0] NEG_INF = 32'hFF800000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [31:0] QNAN    = 32'h7FC00000;

  // ln(1+u) ~= u * (c1 + c2*u + ... + c7*u^6) for u in [0,1).
  // Chebyshev-economised from a degree-8 minimax fit; max error about 1e-6.
  localparam logic [31:0] LN_COEF [1:LN_DEGREE] = '{
    32'h3F7FFE1D,  // c1 =  0.9999712
    32'hBEFFAA1D,  // c2 = -0.4993447
    32'h3EA7B674,  // c3 =  0.3275639
    32'hBE65795C,  // c4 = -0.2240958
    32'h3E0754D7,  // c5 =  0.1321596
    32'hBD5AA668,  // c6 = -0.0533814
    32'h3C28559C   // c7 =  0.0102743
  };

  // Result of screening an operand: special=1 means value is the final answer.
  typedef struct packed {
    logic        special;
    logic [31:0] value;
  } special_t;

  function automatic special_t classify(input logic [31:0] a);
    special_t   r;
    logic [7:0] exp_f;
    logic       frac_nz;
    exp_f      = a[30:23];
    frac_nz    = |a[22:0];
    r.special  = 1'b1;
    r.value    = '0;
    if (exp_f == 8'd0) begin
      r.value = NEG_INF;                 // +/-0 and denormals
    end else if (exp_f == 8'hFF && frac_nz) begin
      r.value = QNAN;                    // any NaN
    end else if (a[31]) begin
      r.value = QNAN;                    // negative, including -inf
    end else if (exp_f == 8'hFF) begin
      r.value = POS_INF;                 // +inf
    end else begin
      r.special = 1'b0;
    end
    return r;
  endfunction

  // Coefficient lookup; indices outside 1..LN_DEGREE read as zero.
  function automatic logic [31:0] ln_coef(input int idx);
    logic [31:0] c;
    c = '0;
    for (int i = 1; i <= LN_DEGREE; i++) begin
      if (idx == i) c = LN_COEF[i];
    end
    return c;
  endfunction

endpackage

// File: rtl/ln_adjust.sv
// Range reduction for ln: splits a positive normal operand into
// x = mantissa in [1,2) and n = unbiased exponent as a float.
module ln_adjust
  import ln_pkg::*;
(
  input  logic [30:0] a_mag,
  output logic [31:0] x,
  output logic [31:0] n
);

  logic [7:0]  exp_raw;
  logic        neg;
  logic [6:0]  mag;
  logic [2:0]  msb;
  logic [22:0] frac;

  assign x = {1'b0, FP_BIAS, a_mag[22:0]};

  // Integer-to-float conversion of (exponent - bias); |n| <= 127 fits in 7 bits.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    msb     = '0;
    exp_raw = a_mag[30:23];
    neg     = exp_raw < FP_BIAS;
    mag     = neg ? 7'(FP_BIAS - exp_raw) : 7'(exp_raw - FP_BIAS);
    for (int i = 0; i < 7; i++) begin
      if (mag[i]) msb = 3'(i);
    end
    // Shift the leading one up to bit 23, where it falls off the fraction field.
    frac = 23'(mag) << (5'd23 - {2'd0, msb});
    n    = (mag == '0) ? '0 : {neg, FP_BIAS + {5'd0, msb}, frac};
  end

endmodule

// File: rtl/ln_sequencer.sv
// Natural-log sequencer: range reduction, Horner evaluation of ln(1+u)/u and
// final n*LN2 + u*P(u), time-sharing one external FP multiplier and adder.
module ln_sequencer
  import ln_pkg::*;
#(
  parameter int DEGREE = LN_DEGREE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_y,
  output logic        busy,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_y,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_y
);

  localparam int K_W = $clog2(DEGREE);

  state_e         state_q, state_d;
  logic [30:0]    a_q, a_d;          // only positive operands reach reduction
  logic [31:0]    acc_q, acc_d;
  logic [31:0]    u_q, u_d;
  logic [31:0]    t_q, t_d;
  logic [K_W-1:0] k_q, k_d;
  logic [31:0]    out_y_q, out_y_d;
  logic           out_valid_q, out_valid_d;

  logic [31:0]    red_x, red_n;
  special_t       cls;
  logic           accept;

  ln_adjust u_adjust (
    .a_mag (a_q),
    .x     (red_x),
    .n     (red_n)
  );

  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign accept    = in_valid && in_ready;
  assign cls       = classify(in_a);

  // Next-state, datapath updates and shared-unit operand steering.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    acc_d       = acc_q;
    u_d         = u_q;
    t_d         = t_q;
    k_d         = k_q;
    out_y_d     = out_y_q;
    out_valid_d = out_valid_q;
    mul_a       = '0;
    mul_b       = '0;
    add_a       = '0;
    add_b       = '0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (cls.special) begin
            out_y_d     = cls.value;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            a_d     = in_a[30:0];
            state_d = REDUCE;
          end
        end
      end
      REDUCE: begin
        add_a   = red_x;
        add_b   = NEG_ONE;
        u_d     = add_y;
        acc_d   = ln_coef(DEGREE);
        k_d     = K_W'(DEGREE - 1);
        state_d = HMUL;
      end
      HMUL: begin
        mul_a   = acc_q;
        mul_b   = u_q;
        acc_d   = mul_y;
        state_d = HADD;
      end
      HADD: begin
        add_a   = acc_q;
        add_b   = ln_coef(int'(k_q));
        acc_d   = add_y;
        k_d     = k_q - K_W'(1);
        state_d = (k_q == K_W'(1)) ? FMUL : HMUL;
      end
      FMUL: begin
        mul_a   = acc_q;
        mul_b   = u_q;
        acc_d   = mul_y;
        state_d = SMUL;
      end
      SMUL: begin
        mul_a   = red_n;
        mul_b   = LN2;
        t_d     = mul_y;
        state_d = SADD;
      end
      SADD: begin
        add_a       = acc_q;
        add_b       = t_q;
        out_y_d     = add_y;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      // NOTE: datapath registers are cleared too, so a reset mid-operation leaves no stale result.
      state_q     <= IDLE;
      a_q         <= '0;
      acc_q       <= '0;
      u_q         <= '0;
      t_q         <= '0;
      k_q         <= '0;
      out_y_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      acc_q       <= acc_d;
      u_q         <= u_d;
      t_q         <= t_d;
      k_q         <= k_d;
      out_y_q     <= out_y_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_ln_sequencer.sv
// Scoreboard bench for ln_sequencer: behavioural FP multiplier and adder,
// directed operands with hand-computed ln values, decoupled output monitor.
module tb_ln_sequencer;
  import ln_pkg::*;

  localparam int DEG     = 7;
  localparam int LAT     = 2 * DEG + 2;  // edges from accept edge to result for normal operands
  localparam int K_NONE  = 0;            // no result expected (aborted operation)
  localparam int K_EXACT = 1;            // special case: exact bit pattern, same-edge result
  localparam int K_APPRX = 2;            // |out - val| < 1e-3
  localparam int K_ZERO  = 3;            // +0.0 or -0.0

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic        busy;
  logic [31:0] mul_a, mul_b, mul_y;
  logic [31:0] add_a, add_b, add_y;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int shared_viol = 0;
  int idle_viol   = 0;

  int          exp_kind_q[$];
  logic [31:0] exp_bits_q[$];
  real         exp_val_q[$];
  int          exp_lat_q[$];
  int          exp_acc_q[$];
  string       exp_name_q[$];

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] held_y     = '0;

  ln_sequencer #(.DEGREE(DEG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .busy      (busy),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_y     (mul_y),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_y     (add_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic real sp_to_real(input logic [31:0] b);
    if (b[30:23] == 8'd0) return 0.0;
    if (b[30:23] == 8'hFF) return $bitstoreal({b[31], 11'h7FF, b[22:0], 29'd0});
    return $bitstoreal({b[31], 11'(32'(b[30:23]) + 32'd896), b[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] real_to_sp(input real r);
    logic [63:0] d;
    int          e;
    logic [23:0] m;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e = int'(d[62:52]) - 896;
    m = {1'b0, d[51:29]} + 24'(d[28]);
    if (m[23]) begin
      e = e + 1;
      m = '0;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0) return {d[63], 31'd0};
    return {d[63], e[7:0], m[22:0]};
  endfunction

  // Shared combinational FP units wrapped around the sequencer.
  always_comb mul_y = real_to_sp(sp_to_real(mul_a) * sp_to_real(mul_b));
  always_comb add_y = real_to_sp(sp_to_real(add_a) + sp_to_real(add_b));

  task automatic check(input string name, input bit ok, input string got, input string want);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s, want %s", name, got, want);
    end
  endtask

  // Issue one operand; push its expected result once the accept edge has passed.
  task automatic apply(input logic [31:0] a, input int kind, input logic [31:0] bits,
                       input real val, input string name);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check({name, "_accept"}, 1'b0, "in_ready=0 after 200 cycles", "in_ready=1");
      return;
    end
    in_valid = 1'b1;
    in_a     = a;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = '0;
    if (kind != K_NONE) begin
      exp_kind_q.push_back(kind);
      exp_bits_q.push_back(bits);
      exp_val_q.push_back(val);
      // Special results appear in the cycle right after the accepting cycle.
      exp_lat_q.push_back(kind == K_EXACT ? 0 : LAT);
      exp_acc_q.push_back(cyc);
      exp_name_q.push_back(name);
    end
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while (busy && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (busy) check({name, "_idle_timeout"}, 1'b0, "busy=1", "busy=0");
  endtask

  // Monitor: compares each result as it appears, and watches hold/handshake rules.
  always @(negedge clk) begin
    int          kind;
    logic [31:0] bits;
    real         val;
    real         got;
    real         diff;
    int          lat;
    int          acc;
    string       name;
    if ((mul_a != '0 || mul_b != '0) && (add_a != '0 || add_b != '0))
      shared_viol <= shared_viol + 1;
    if ((!busy || out_valid) && (mul_a | mul_b | add_a | add_b) != '0)
      idle_viol <= idle_viol + 1;

    if (prev_valid && prev_ready) begin
      check("take_to_idle", !out_valid && !busy,
            $sformatf("valid=%0b busy=%0b", out_valid, busy), "valid=0 busy=0");
    end else if (prev_valid && out_valid) begin
      check("hold_out_y", out_y == held_y, $sformatf("%08h", out_y), $sformatf("%08h", held_y));
      check("hold_in_ready", in_ready == 1'b0, $sformatf("%0b", in_ready), "0");
    end

    if (out_valid && !prev_valid) begin
      if (exp_kind_q.size() == 0) begin
        check("unexpected_output", 1'b0, $sformatf("%08h", out_y), "no output");
      end else begin
        kind = exp_kind_q.pop_front();
        bits = exp_bits_q.pop_front();
        val  = exp_val_q.pop_front();
        lat  = exp_lat_q.pop_front();
        acc  = exp_acc_q.pop_front();
        name = exp_name_q.pop_front();
        if (kind == K_EXACT) begin
          check(name, out_y == bits, $sformatf("%08h", out_y), $sformatf("%08h", bits));
        end else if (kind == K_ZERO) begin
          check(name, out_y == 32'h0000_0000 || out_y == 32'h8000_0000,
                $sformatf("%08h", out_y), "00000000 or 80000000");
        end else begin
          got  = sp_to_real(out_y);
          diff = (got > val) ? got - val : val - got;
          check(name, diff < 1.0e-3, $sformatf("%f (%08h)", got, out_y), $sformatf("%f", val));
        end
        check({name, "_latency"}, (cyc - acc) == lat, $sformatf("%0d", cyc - acc), $sformatf("%0d", lat));
      end
      held_y <= out_y;
    end
    prev_valid <= out_valid;
    prev_ready <= out_ready;
  end

  initial begin
    int w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid == 1'b0, $sformatf("%0b", out_valid), "0");
    check("rst_out_y", out_y == 32'h0, $sformatf("%08h", out_y), "00000000");
    check("rst_busy", busy == 1'b0, $sformatf("%0b", busy), "0");
    check("rst_in_ready", in_ready == 1'b0, $sformatf("%0b", in_ready), "0");
    rst = 1'b0;
    #1;
    check("rel_in_ready", in_ready == 1'b1, $sformatf("%0b", in_ready), "1");

    // Normal operands.
    apply(32'h4000_0000, K_APPRX, '0,  0.693147, "ln_2");
    apply(32'h3F80_0000, K_ZERO,  '0,  0.0,      "ln_1");
    apply(32'h42C8_0000, K_APPRX, '0,  4.605170, "ln_100");
    apply(32'h3F00_0000, K_APPRX, '0, -0.693147, "ln_0p5");
    apply(32'h4120_0000, K_APPRX, '0,  2.302585, "ln_10");
    apply(32'h3FC0_0000, K_APPRX, '0,  0.405465, "ln_1p5");
    apply(32'h3FFF_FFFF, K_APPRX, '0,  0.693147, "ln_2_minus_ulp");
    apply(32'h3DCC_CCCD, K_APPRX, '0, -2.302585, "ln_0p1");
    apply(32'h7F00_0000, K_APPRX, '0, 88.029692, "ln_2p127");
    apply(32'h0080_0000, K_APPRX, '0, -87.336545, "ln_min_normal");

    // Special operands.
    apply(32'h0000_0000, K_EXACT, 32'hFF80_0000, 0.0, "sp_pos_zero");
    apply(32'h8000_0000, K_EXACT, 32'hFF80_0000, 0.0, "sp_neg_zero");
    apply(32'h0000_0001, K_EXACT, 32'hFF80_0000, 0.0, "sp_denormal");
    apply(32'h8000_0001, K_EXACT, 32'hFF80_0000, 0.0, "sp_neg_denormal");
    apply(32'hBF80_0000, K_EXACT, 32'h7FC0_0000, 0.0, "sp_neg_one");
    apply(32'h7FC0_0001, K_EXACT, 32'h7FC0_0000, 0.0, "sp_nan");
    apply(32'hFF80_0000, K_EXACT, 32'h7FC0_0000, 0.0, "sp_neg_inf");
    apply(32'h7F80_0000, K_EXACT, 32'h7F80_0000, 0.0, "sp_pos_inf");

    // Backpressure: result held five cycles with out_ready low.
    wait_idle("bp");
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    apply(32'h4000_0000, K_APPRX, '0, 0.693147, "bp_ln_2");
    w = 0;
    while (!out_valid && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("bp_valid_seen", out_valid == 1'b1, $sformatf("%0b", out_valid), "1");
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Reset pulse while the sequencer is in HMUL aborts the operation.
    wait_idle("rst_mid");
    apply(32'h4000_0000, K_NONE, '0, 0.0, "aborted");
    @(posedge clk);
    #1;
    check("rst_mid_in_hmul", dut.state_q == HMUL, $sformatf("%0d", dut.state_q), $sformatf("%0d", HMUL));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_cleared", !busy && !out_valid && !in_ready,
          $sformatf("busy=%0b valid=%0b ready=%0b", busy, out_valid, in_ready),
          "busy=0 valid=0 ready=0");
    rst = 1'b0;
    #1;
    check("rst_mid_in_ready", in_ready == 1'b1, $sformatf("%0b", in_ready), "1");
    apply(32'h4000_0000, K_APPRX, '0, 0.693147, "after_rst_ln_2");

    w = 0;
    while (exp_kind_q.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    repeat (20) @(posedge clk);
    #1;
    check("drain", exp_kind_q.size() == 0, $sformatf("%0d pending", exp_kind_q.size()), "0 pending");
    check("one_shared_unit", shared_viol == 0, $sformatf("%0d cycles", shared_viol), "0 cycles");
    check("unused_operands_zero", idle_viol == 0, $sformatf("%0d cycles", idle_viol), "0 cycles");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
